// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with a programmable SCK divider, all four SPI modes,
// MSB/LSB-first selection and one-hot active-low chip selects.
module spi_master_cfg #(
  parameter int FRAME_W = 8,
  parameter int NUM_CS  = 4,
  parameter int DIV_W   = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           cpol,
  input  logic                                           cpha,
  input  logic                                           lsb_first,
  input  logic [DIV_W-1:0]                               div,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
  input  logic                                           tx_valid,
  output logic                                           tx_ready,
  input  logic [FRAME_W-1:0]                             tx_data,
  output logic                                           rx_valid,
  output logic [FRAME_W-1:0]                             rx_data,
  output logic                                           busy,
  output logic                                           sck,
  output logic                                           mosi,
  input  logic                                           miso,
  output logic [NUM_CS-1:0]                              cs_n
);

  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int BC_W = $clog2(FRAME_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   cnt;
  logic               cpha_q;
  logic               lsb_q;
  logic [FRAME_W-1:0] tx_sr;
  logic [FRAME_W-1:0] rx_sr;
  logic [BC_W-1:0]    bit_cnt;
  logic               trail;
  logic               half_done;

  assign half_done = (cnt == div_q);

  function automatic logic first_bit(input logic [FRAME_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[FRAME_W-1];
  endfunction

  function automatic logic [FRAME_W-1:0] shift_out(input logic [FRAME_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [FRAME_W-1:0] shift_in(input logic [FRAME_W-1:0] sr, input logic b,
                                                  input logic lsb);
    return lsb ? {b, sr[FRAME_W-1:1]} : {sr[FRAME_W-2:0], b};
  endfunction

  // An out-of-range index matches no slave, so every select stays high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] res;
    for (int i = 0; i < NUM_CS; i++) res[i] = (32'(sel) != i);
    return res;
  endfunction

  // NOTE: every register here uses non-blocking assignment so all state
  // updates in a cycle see the pre-edge values, matching real flip-flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_q    <= '0;
      cnt      <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      trail    <= 1'b0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sck  <= cpol;
          cs_n <= '1;
          if (tx_valid && tx_ready) begin
            div_q    <= div;
            cpha_q   <= cpha;
            lsb_q    <= lsb_first;
            cnt      <= '0;
            bit_cnt  <= '0;
            trail    <= 1'b0;
            cs_n     <= cs_decode(cs_sel);
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state    <= SETUP;
            // Leading-edge sampling needs the first bit on the wire during SETUP.
            if (!cpha) begin
              mosi  <= first_bit(tx_data, lsb_first);
              tx_sr <= shift_out(tx_data, lsb_first);
            end else begin
              tx_sr <= tx_data;
            end
          end
        end
        SETUP: begin
          if (half_done) begin
            cnt   <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (half_done) begin
            cnt   <= '0;
            sck   <= ~sck;
            trail <= ~trail;
            if (!trail) begin
              if (!cpha_q) begin
                rx_sr <= shift_in(rx_sr, miso, lsb_q);
              end else begin
                mosi  <= first_bit(tx_sr, lsb_q);
                tx_sr <= shift_out(tx_sr, lsb_q);
              end
            end else begin
              if (cpha_q) begin
                rx_sr <= shift_in(rx_sr, miso, lsb_q);
              end else if (bit_cnt != LAST_BIT) begin
                mosi  <= first_bit(tx_sr, lsb_q);
                tx_sr <= shift_out(tx_sr, lsb_q);
              end
              if (bit_cnt == LAST_BIT) state <= HOLD;
              else                     bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (half_done) begin
            cnt      <= '0;
            cs_n     <= '1;
            rx_valid <= 1'b1;
            rx_data  <= rx_sr;
            state    <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (half_done) begin
            cnt      <= '0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: queued expected rx frames are popped by a
// monitor on every rx_valid; pin timing is measured alongside.
module tb_spi_master_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] div = 8'd0;
  logic [1:0] cs_sel = 2'd0;
  logic [2:0] cs_sel5 = 3'd5;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       loop = 1'b1;
  logic       slave_miso = 1'b0;
  logic       slave_en = 1'b0;

  logic       tx_ready, rx_valid, busy, sck, mosi, miso;
  logic [7:0] rx_data;
  logic [3:0] cs_n;
  logic       tx_ready5, rx_valid5, busy5, sck5, mosi5;
  logic [7:0] rx_data5;
  logic [4:0] cs_n5;

  always #5 clk = ~clk;
  assign miso = loop ? mosi : slave_miso;

  spi_master_cfg #(.FRAME_W(8), .NUM_CS(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .div(div),
    .cs_sel(cs_sel), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sck(sck), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  // Same stimulus, but the slave index is out of range for five selects.
  spi_master_cfg #(.FRAME_W(8), .NUM_CS(5), .DIV_W(8)) dut5 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .div(div),
    .cs_sel(cs_sel5), .tx_valid(tx_valid), .tx_ready(tx_ready5), .tx_data(tx_data),
    .rx_valid(rx_valid5), .rx_data(rx_data5), .busy(busy5), .sck(sck5), .mosi(mosi5),
    .miso(mosi5), .cs_n(cs_n5)
  );

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int rx_cnt = 0, rx5_cnt = 0, frames = 0;
  int cs_low = 0, edges = 0, mosi_hi = 0, cs5_low = 0, hi_run = 0, min_hi = 999;
  logic [3:0] cs_and = 4'hf, cs_or = 4'h0;
  logic sck_prev = 1'b0;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus pin measurement and a mode-3 slave model.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got rx_valid with data 0x%0h, expected none", rx_data);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (rx_valid5) rx5_cnt++;
      if (cs_n5 != 5'h1f) cs5_low++;
      if (cs_n != 4'hf) begin
        cs_low++;
        cs_and = cs_and & cs_n;
        cs_or  = cs_or | cs_n;
        if (mosi) mosi_hi++;
        if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
        hi_run = 0;
        if (slave_en && sck_prev && !sck) begin
          slave_miso = s_tx[7];
          s_tx = s_tx << 1;
        end
        if (slave_en && !sck_prev && sck) s_rx = {s_rx[6:0], mosi};
      end else begin
        hi_run++;
      end
      if (sck !== sck_prev) edges++;
      sck_prev = sck;
    end
  end

  task automatic clr();
    cs_low = 0; edges = 0; mosi_hi = 0; cs_and = 4'hf; cs_or = 4'h0;
  endtask

  task automatic start(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n < 5000, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] data[3];
    int acc_t[3];
    int acc, t, n, rc;
    data[0] = 8'h12; data[1] = 8'h34; data[2] = 8'h56;

    // Reset values, then sck must follow cpol once released
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 4'hf);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_sck_cpol", sck, 1);
    cpol = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0, div 0, loopback 0xA5
    clr();
    exp_q.push_back(8'hA5);
    start(8'hA5);
    wait_idle();
    frames++;
    check("m0_cs_low_cycles", cs_low, 18);
    check("m0_sck_edges", edges, 16);
    check("m0_rx_pulses", rx_cnt, 1);

    // Mode 3, div 3, slave returns 0x3C
    cpol = 1'b1; cpha = 1'b1; div = 8'd3; loop = 1'b0;
    slave_en = 1'b1; s_tx = 8'h3C; s_rx = 8'h00;
    repeat (3) @(negedge clk);
    check("m3_sck_idle", sck, 1);
    clr();
    exp_q.push_back(8'h3C);
    start(8'h81);
    wait_idle();
    frames++;
    slave_en = 1'b0;
    check("m3_slave_rx", s_rx, 8'h81);
    check("m3_cs_low_cycles", cs_low, 72);
    check("m3_sck_edges", edges, 16);
    check("m3_sck_end", sck, 1);

    // cs_sel = 2, mode 0, loopback 0x3C
    cpol = 1'b0; cpha = 1'b0; div = 8'd0; loop = 1'b1; cs_sel = 2'd2;
    repeat (2) @(negedge clk);
    clr();
    exp_q.push_back(8'h3C);
    start(8'h3C);
    wait_idle();
    frames++;
    check("cs2_and", cs_and, 4'b1011);
    check("cs2_or", cs_or, 4'b1011);
    check("cs2_after", cs_n, 4'hf);

    // LSB first, mode 1, div 1, 0x01
    cpha = 1'b1; lsb_first = 1'b1; div = 8'd1; cs_sel = 2'd0;
    repeat (2) @(negedge clk);
    clr();
    exp_q.push_back(8'h01);
    start(8'h01);
    wait_idle();
    frames++;
    check("lsb_mosi_high_cycles", mosi_hi, 4);
    check("lsb_cs_low_cycles", cs_low, 36);

    // Back-to-back frames, div 1, mode 0
    cpha = 1'b0; lsb_first = 1'b0; div = 8'd1;
    repeat (2) @(negedge clk);
    min_hi = 999;
    tx_data = data[0];
    tx_valid = 1'b1;
    acc = 0; t = 0; n = 0;
    while (acc < 3 && n < 1000) begin
      if (tx_valid && tx_ready) begin
        acc_t[acc] = t;
        exp_q.push_back(data[acc]);
        acc++;
        @(negedge clk);
        t++;
        if (acc < 3) tx_data = data[acc];
        else         tx_valid = 1'b0;
      end else begin
        @(negedge clk);
        t++;
        n++;
      end
    end
    tx_valid = 1'b0;
    check("b2b_accepts", acc, 3);
    wait_idle();
    frames += 3;
    check("b2b_spacing_1", acc_t[1] - acc_t[0], 39);
    check("b2b_spacing_2", acc_t[2] - acc_t[1], 39);
    check("b2b_cs_gap", min_hi, 3);

    // Reset mid-transfer aborts without rx_valid
    clr();
    tx_data = 8'hF0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (edges < 9 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_bit4", edges >= 9, 1);
    rc = rx_cnt;
    #1 rst = 1'b1;
    #1;
    check("abort_cs_n", cs_n, 4'hf);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_ready", tx_ready, 1);
    check("abort_rx_data", rx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_no_rx_valid", rx_cnt, rc);
    clr();
    exp_q.push_back(8'h5A);
    start(8'h5A);
    wait_idle();
    frames++;
    check("post_abort_edges", edges, 16);

    // Out-of-range select instance and scoreboard drain
    repeat (3) @(negedge clk);
    check("cs5_never_low", cs5_low, 0);
    check("cs5_frames", rx5_cnt, frames);
    check("rx_frames", rx_cnt, frames);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_cfg.md
# spi_master_cfg

Parametrised, full-duplex SPI master with a runtime-programmable SCK divider, all four SPI modes, MSB/LSB-first selection and one-hot active-low chip selects for `NUM_CS` slaves. It sits between a host-side valid/ready byte stream and the SPI pins. It replaces free-running SCK generation and unsynchronised receive sampling with a single clk-domain state machine that has defined CS setup, hold and inter-frame gap.

## Interface
- `FRAME_W`, 8: bits per frame (≥2).
- `NUM_CS`, 4: number of slave selects (≥1, need not be power of 2).
- `DIV_W`, 8: width of `div`.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpol` in 1: SCK idle level.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `lsb_first` in 1: 1 = LSB shifted first on MOSI and received first.
- `div` in DIV_W: SCK half-period = `div+1` clk cycles.
- `cs_sel` in max(1,$clog2(NUM_CS)): target slave index.
- `tx_valid` in 1 / `tx_ready` out 1 / `tx_data` in FRAME_W: frame request handshake.
- `rx_valid` out 1 / `rx_data` out FRAME_W: received frame, single-cycle pulse, no backpressure.
- `busy` out 1: high whenever state ≠ IDLE.
- `sck` out 1, `mosi` out 1, `miso` in 1, `cs_n` out NUM_CS: SPI pins, all outputs registered.

## Operation
- States: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE: `tx_ready`=1; `sck` follows `cpol`; `cs_n` all ones. Accept on `tx_valid && tx_ready`.
- On accept, latch `cpol`, `cpha`, `lsb_first`, `div`, `cs_sel` and `tx_data`. Input changes during a frame are ignored.
- SETUP, one half-period: assert `cs_n[cs_sel]`=0.
  - `cpha`=0: drive the first data bit on `mosi`.
  - `cs_sel` ≥ NUM_CS: no `cs_n` asserts, but the frame still runs.
- XFER: 2·FRAME_W half-periods, with an SCK toggle at the end of each.
  - `cpha`=0: sample `miso` on the leading edge and shift the next bit out on the trailing edge. No shift after the final edge.
  - `cpha`=1: shift out on the leading edge (the first bit appears with the first edge) and sample on the trailing edge.
  - Bit counter counts 0..FRAME_W-1 and terminates without wrap.
- HOLD, one half-period: `sck` at idle level, `cs_n` still asserted.
- End of HOLD, same cycle:
  - `cs_n` returns to all ones.
  - `rx_valid`=1 for exactly one cycle.
  - `rx_data` is updated; it is held until the next frame completes.
- GAP, one half-period: `cs_n` high, `busy`=1, `tx_ready`=0. Then return to IDLE.
- `mosi` holds its last driven bit outside XFER. It is not tri-stated.
- `rst` assertion at any point forces the reset values immediately and aborts an in-flight frame. No `rx_valid` is produced for the aborted frame.

## Timing
- Reset values: `sck`=0, `mosi`=0, `cs_n`=all ones, `rx_valid`=0, `rx_data`=0, `busy`=0, `tx_ready`=1, state=IDLE.
- The first IDLE cycle after reset drives `sck`=`cpol`.
- Let H = `div`+1.
- Accept at cycle T: `busy`=1 and `cs_n` asserted from T+1.
- `cs_n` is low for exactly (2·FRAME_W+2)·H cycles.
- `rx_valid` is high in the first cycle with `cs_n` high.
- `tx_ready` rises H cycles after `rx_valid`. Minimum accept-to-accept spacing is (2·FRAME_W+3)·H+1 cycles.
- `tx_valid` held high gives back-to-back frames at that spacing.
- `div`=0 gives SCK = clk/2. `div`=2^DIV_W−1 must work with no counter overflow (counter is DIV_W bits and compares with the latched `div`).
- `miso` is sampled in the clk cycle in which `sck` toggles to the sampling edge. The slave has ≥H−1 clk cycles of setup.

## Test plan
- Mode 0, `div`=0, FRAME_W=8, `miso` looped to `mosi`, `tx_data`=0xA5 → `rx_data`=0xA5; 16 SCK edges; `cs_n` low 18 cycles; one `rx_valid` pulse.
- Mode 3 (`cpol`=1, `cpha`=1), `div`=3, slave model returns 0x3C, `tx_data`=0x81 → slave receives 0x81 and `rx_data`=0x3C. `sck` idles high; each half-period is 4 cycles.
- `lsb_first`=1, mode 1, `tx_data`=0x01 → `mosi` high only during the first bit; loopback `rx_data`=0x01.
- `cs_sel`=2, NUM_CS=4 → `cs_n`=4'b1011 during the frame and 4'b1111 otherwise. With `cs_sel`=5 and NUM_CS=5 (out of range) → `cs_n` all ones, frame still completes.
- `tx_valid` held high for 3 frames, `div`=1 → accepts spaced exactly 39 cycles apart; `cs_n` high ≥2 cycles between frames.
- `rst` pulse mid-XFER (after bit 4) → `cs_n` all ones and `sck`=0 immediately; no `rx_valid`; next frame after release completes correctly.
